// File: rtl/fpu_pkg.sv
// Shared FPU types and helpers: binary32 field view, rounding modes, canonical constants
// and operand classification.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rm_e;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_INF  = 32'h7F800000;
  localparam logic [31:0] FP_MAXF = 32'h7F7FFFFF;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } fp_class_t;

  // Denormal encodings are classified as zero: the datapath flushes them on input.
  function automatic fp_class_t fp_class(input fp32_t f);
    fp_class_t c;
    c.zero = (f.exp == 8'h00);
    c.inf  = (f.exp == 8'hFF) && (f.man == 23'd0);
    c.nan  = (f.exp == 8'hFF) && (f.man != 23'd0);
    c.snan = c.nan && !f.man[22];
    return c;
  endfunction

endpackage

// File: rtl/fmul_round_pack.sv
// Normalise, round (RNE or RTZ) and pack a 48-bit significand product into binary32,
// flagging overflow and flush-to-zero underflow.
module fmul_round_pack
  import fpu_pkg::*;
(
  input  logic        [47:0] prod,
  input  logic signed [9:0]  exp_in,
  input  logic               sign,
  input  rm_e                rm,
  output logic        [31:0] y,
  output logic               ovf,
  output logic               unf
);

  logic        [22:0] mant;
  logic               guard;
  logic               sticky;
  logic               inc;
  logic        [23:0] mant_r;
  logic signed [9:0]  exp_n;
  logic signed [9:0]  exp_r;

  always_comb begin
    mant   = 23'd0;
    guard  = 1'b0;
    sticky = 1'b0;
    inc    = 1'b0;
    mant_r = 24'd0;
    exp_n  = exp_in;
    exp_r  = exp_in;
    ovf    = 1'b0;
    unf    = 1'b0;
    y      = 32'd0;

    // Both significands carry a hidden one, so the product leads at bit 47 or 46.
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp_in + 10'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_n  = exp_in;
    end

    inc    = (rm == RM_RNE) && guard && (sticky || mant[0]);
    mant_r = {1'b0, mant} + {23'd0, inc};
    exp_r  = exp_n + (mant_r[23] ? 10'sd1 : 10'sd0);

    ovf = (exp_r >= 10'sd255);
    unf = !ovf && (exp_r <= 10'sd0);

    if (ovf) begin
      y = (rm == RM_RTZ) ? {sign, FP_MAXF[30:0]} : {sign, FP_INF[30:0]};
    end else if (unf) begin
      y = {sign, 31'd0};
    end else begin
      y = {sign, exp_r[7:0], mant_r[22:0]};
    end
  end

endmodule

// File: rtl/fmul_pipe.sv
// Elastic binary32 multiplier: classify and multiply into stage 1, optional retiming
// registers, then round/pack into the output register. One global stall freezes all stages.
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int NSTAGE = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic             rm,
  input  logic             flag_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [2:0]       exc,
  output logic             flag_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int NMID = NSTAGE - 1;

  // Handshake: an op moves from in_* into the pipe when in_valid && in_ready, and the
  // result on out_* is consumed when out_valid && out_ready. in_ready depends only on
  // registered out_valid and the consumer's out_ready, never on in_valid.
  typedef struct packed {
    logic             valid;
    logic             flag;
    logic [TAG_W-1:0] tag;
    logic             sign;
    logic             rm;
    logic             spec;
    logic [31:0]      spec_y;
    logic             spec_nv;
    logic [47:0]      prod;
    logic [9:0]       exp;
  } mid_t;

  fp32_t     a;
  fp32_t     b;
  fp_class_t ca;
  fp_class_t cb;
  mid_t      mid_d;
  mid_t      mid_last;
  logic      stall;
  logic      advance;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      y_q, y_d;
  logic [2:0]       exc_q, exc_d;
  logic             flag_q, flag_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [31:0] rp_y;
  logic        rp_ovf;
  logic        rp_unf;

  assign stall    = out_valid_q & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;

  assign a = x1;
  assign b = x2;

  always_comb begin
    ca    = fp_class(a);
    cb    = fp_class(b);
    mid_d = '0;

    mid_d.valid = in_valid;
    mid_d.flag  = flag_in;
    mid_d.tag   = tag_in;
    mid_d.sign  = a.sign ^ b.sign;
    mid_d.rm    = rm;
    mid_d.prod  = 48'({1'b1, a.man}) * 48'({1'b1, b.man});
    mid_d.exp   = {2'b00, a.exp} + {2'b00, b.exp} - 10'd127;

    if (ca.nan || cb.nan) begin
      mid_d.spec    = 1'b1;
      mid_d.spec_y  = FP_QNAN;
      mid_d.spec_nv = ca.snan || cb.snan;
    end else if ((ca.inf && cb.zero) || (ca.zero && cb.inf)) begin
      mid_d.spec    = 1'b1;
      mid_d.spec_y  = FP_QNAN;
      mid_d.spec_nv = 1'b1;
    end else if (ca.inf || cb.inf) begin
      mid_d.spec   = 1'b1;
      mid_d.spec_y = {mid_d.sign, FP_INF[30:0]};
    end else if (ca.zero || cb.zero) begin
      mid_d.spec   = 1'b1;
      mid_d.spec_y = {mid_d.sign, 31'd0};
    end
  end

  generate
    if (NMID == 0) begin : g_comb
      assign mid_last = mid_d;
    end else begin : g_mid
      mid_t mid_q [NMID];

      // Extra stages are plain copies of the product record for retiming.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < NMID; i++) mid_q[i] <= '0;
        end else if (advance) begin
          mid_q[0] <= mid_d;
          for (int i = 1; i < NMID; i++) mid_q[i] <= mid_q[i-1];
        end
      end

      assign mid_last = mid_q[NMID-1];
    end
  endgenerate

  fmul_round_pack u_round_pack (
    .prod   (mid_last.prod),
    .exp_in (signed'(mid_last.exp)),
    .sign   (mid_last.sign),
    .rm     (rm_e'(mid_last.rm)),
    .y      (rp_y),
    .ovf    (rp_ovf),
    .unf    (rp_unf)
  );

  always_comb begin
    out_valid_d = mid_last.valid;
    flag_d      = mid_last.flag;
    tag_d       = mid_last.tag;
    y_d         = rp_y;
    exc_d       = {1'b0, rp_ovf, rp_unf};
    if (mid_last.spec) begin
      y_d   = mid_last.spec_y;
      exc_d = {mid_last.spec_nv, 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= 32'd0;
      exc_q       <= 3'd0;
      flag_q      <= 1'b0;
      tag_q       <= '0;
    end else if (advance) begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      exc_q       <= exc_d;
      flag_q      <= flag_d;
      tag_q       <= tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign exc       = exc_q;
  assign flag_out  = flag_q;
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe: directed vector table, randomized ops against a real-arithmetic
// reference model, a mid-stream stall sequence and a reset-with-ops-in-flight sequence.
module tb_fmul_pipe #(
  parameter int NSTAGE = 2
);

  localparam int TAG_W = 5;
  localparam int EW    = 32 + 3 + 1 + TAG_W;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      x1;
  logic [31:0]      x2;
  logic             rm;
  logic             flag_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      y;
  logic [2:0]       exc;
  logic             flag_out;
  logic [TAG_W-1:0] tag_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit lat_chk  = 0;
  bit rand_bp  = 0;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        r;
    logic [31:0] ey;
    logic [2:0]  ee;
  } vec_t;

  fmul_pipe #(.NSTAGE(NSTAGE), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .rm        (rm),
    .flag_in   (flag_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .exc       (exc),
    .flag_out  (flag_out),
    .tag_out   (tag_out)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: exact product in real arithmetic, then round to 24 significant bits.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic r);
    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    bit          nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
    longint      sp;
    real         p, fr;
    int          t, be, ip;
    logic [7:0]  be8;
    logic [22:0] ip23;
    s  = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    ma = a[22:0];  mb = b[22:0];
    nan_a = (ea == 8'hFF) && (ma != 0);
    nan_b = (eb == 8'hFF) && (mb != 0);
    inf_a = (ea == 8'hFF) && (ma == 0);
    inf_b = (eb == 8'hFF) && (mb == 0);
    zer_a = (ea == 0);
    zer_b = (eb == 0);
    if (nan_a || nan_b)
      return {32'h7FC00000, (nan_a && !ma[22]) || (nan_b && !mb[22]), 2'b00};
    if ((inf_a && zer_b) || (zer_a && inf_b)) return {32'h7FC00000, 3'b100};
    if (inf_a || inf_b) return {s, 31'h7F800000, 3'b000};
    if (zer_a || zer_b) return {s, 31'd0, 3'b000};
    sp = longint'({1'b1, ma}) * longint'({1'b1, mb});
    p  = real'(sp);
    t  = 0;
    while (p >= 16777216.0) begin
      p = p / 2.0;
      t++;
    end
    be = t + int'(ea) + int'(eb) - 150;
    ip = $rtoi(p);
    fr = p - $itor(ip);
    if (!r && ((fr > 0.5) || (fr == 0.5 && ip[0]))) ip++;
    if (ip == 16777216) begin
      ip = 8388608;
      be++;
    end
    if (be >= 255) return r ? {s, 31'h7F7FFFFF, 3'b010} : {s, 31'h7F800000, 3'b010};
    if (be <= 0) return {s, 31'd0, 3'b001};
    be8  = be[7:0];
    ip23 = ip[22:0];
    return {s, be8, ip23, 3'b000};
  endfunction

  function automatic logic [31:0] rand_fp();
    int          k;
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    k = $urandom_range(0, 19);
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom());
    if (k == 0) begin
      e = 8'd0;
      if ($urandom_range(0, 1) == 0) m = 23'd0;
    end else if (k == 1) begin
      e = 8'hFF;
      m = 23'd0;
    end else if (k == 2) begin
      e = 8'hFF;
      if (m == 23'd0) m = 23'd1;
    end else if (k < 9) begin
      e = 8'($urandom_range(100, 154));
    end else begin
      e = 8'($urandom_range(1, 254));
    end
    return {s, e, m};
  endfunction

  // Driver: hold the op until it is accepted, recording the expectation at acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic r,
                      input logic f, input logic [TAG_W-1:0] t, input logic [34:0] ye);
    int waitc;
    bit done;
    waitc = 0;
    done  = 0;
    in_valid = 1'b1;
    x1 = a; x2 = b; rm = r; flag_in = f; tag_in = t;
    while (!done) begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({ye, f, t});
        acc_q.push_back(cyc);
        done = 1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        waitc++;
        if (waitc > 100) begin
          checks++;
          failures++;
          $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", waitc);
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (NSTAGE + 3) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every delivered result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            acc;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got y=%h tag=%h expected no result", y, tag_out);
      end else begin
        e   = exp_q.pop_front();
        acc = acc_q.pop_front();
        check("y", 64'(y), 64'(e[EW-1 -: 32]));
        check("exc", 64'(exc), 64'(e[TAG_W+1 +: 3]));
        check("flag_out", 64'(flag_out), 64'(e[TAG_W]));
        check("tag_out", 64'(tag_out), 64'(e[TAG_W-1:0]));
        if (lat_chk) check("latency", 64'(cyc - acc), 64'(NSTAGE));
      end
    end
  end

  vec_t vecs[20];

  initial begin
    logic [31:0]      sa[8];
    logic [31:0]      sb[8];
    logic             sr[8];
    logic [TAG_W-1:0] stg[8];
    logic [31:0]      ra, rb;
    logic             rr;
    int               n, c;
    bit               win;

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
    vecs[1]  = '{32'h3F800800, 32'h3F800800, 1'b0, 32'h3F801000, 3'b000};
    vecs[2]  = '{32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 3'b000};
    vecs[3]  = '{32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, 3'b000};
    vecs[4]  = '{32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 3'b010};
    vecs[5]  = '{32'h7F000000, 32'h40000000, 1'b1, 32'h7F7FFFFF, 3'b010};
    vecs[6]  = '{32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 3'b001};
    vecs[7]  = '{32'h80800000, 32'h3F000000, 1'b0, 32'h80000000, 3'b001};
    vecs[8]  = '{32'h00400000, 32'h40000000, 1'b0, 32'h00000000, 3'b000};
    vecs[9]  = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 3'b100};
    vecs[10] = '{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 3'b000};
    vecs[11] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100};
    vecs[12] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000};
    vecs[13] = '{32'h3F800800, 32'h3F801800, 1'b0, 32'h3F802002, 3'b000};
    vecs[14] = '{32'h3F800800, 32'h3F801800, 1'b1, 32'h3F802001, 3'b000};
    vecs[15] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'hBF800000, 3'b000};
    vecs[16] = '{32'h80000000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100};
    vecs[17] = '{32'hFF800000, 32'hFF800000, 1'b0, 32'h7F800000, 3'b000};
    vecs[18] = '{32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 3'b000};
    vecs[19] = '{32'h00800001, 32'h3F7FFFFF, 1'b0, 32'h00800000, 3'b000};

    // Reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x1 = '0; x2 = '0; rm = 1'b0; flag_in = 1'b0; tag_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_exc", 64'(exc), 64'd0);
    check("rst_flag_out", 64'(flag_out), 64'd0);
    check("rst_tag_out", 64'(tag_out), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors, back to back, with latency tracking
    lat_chk = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) send(vecs[i].a, vecs[i].b, vecs[i].r, 1'b1, 5'h13, {vecs[i].ey, vecs[i].ee});
      else send(vecs[i].a, vecs[i].b, vecs[i].r, 1'($urandom_range(0, 1)),
                TAG_W'($urandom()), {vecs[i].ey, vecs[i].ee});
    end
    drain();
    lat_chk = 0;

    // Randomized ops with random backpressure and idle gaps
    rand_bp = 1;
    for (int i = 0; i < 300; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      rr = 1'($urandom_range(0, 1));
      send(ra, rb, rr, 1'($urandom_range(0, 1)), TAG_W'($urandom()), model(ra, rb, rr));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_bp = 0;
    drain();

    // Continuous stream of 8 ops with a 3-cycle consumer stall mid-stream
    for (int i = 0; i < 8; i++) begin
      sa[i] = rand_fp(); sb[i] = rand_fp();
      sr[i] = 1'($urandom_range(0, 1)); stg[i] = TAG_W'($urandom());
    end
    n = 0;
    c = 0;
    while (n < 8 && c < 40) begin
      win = (c >= NSTAGE + 1) && (c <= NSTAGE + 3);
      out_ready = !win;
      in_valid = 1'b1;
      x1 = sa[n]; x2 = sb[n]; rm = sr[n]; flag_in = stg[n][0]; tag_in = stg[n];
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'(!win));
      if (in_ready) begin
        exp_q.push_back({model(sa[n], sb[n], sr[n]), stg[n][0], stg[n]});
        acc_q.push_back(cyc);
        n++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    in_valid = 1'b0;
    check("stall_ops_sent", 64'(n), 64'd8);
    drain();

    // Reset with two ops in flight: nothing stale may emerge afterwards
    ra = rand_fp(); rb = rand_fp();
    send(ra, rb, 1'b0, 1'b1, 5'h0A, model(ra, rb, 1'b0));
    send(rb, ra, 1'b1, 1'b0, 5'h15, model(rb, ra, 1'b1));
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("inflight_rst_out_valid", 64'(out_valid), 64'd0);
    check("inflight_rst_y", 64'(y), 64'd0);
    check("inflight_rst_tag", 64'(tag_out), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(32'h40400000, 32'h40400000, 1'b0, 1'b1, 5'h1F, model(32'h40400000, 32'h40400000, 1'b0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
